mul4s_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4x4 signed (two's complement) array multiplier between two requesters. It accepts an operand pair from the winning requester, registers the operands into the shared combinational multiplier, and captures the 8-bit signed product. It then presents the product on a valid/ready result port tagged with the requester ID. It sits between the requesting datapath blocks and the multiplier instance, which it contains.

---
 rtl/mul4s_if.sv | 12 +
 rtl/mul4s_arbiter.sv | 62 ++++++
 tb/tb_mul4s_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mul4s_if.sv
// mul4s_if: request, grant and result bundle between two requesters, a consumer and the shared-multiplier arbiter
interface mul4s_if;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       gnt0, gnt1;
    logic       res_valid, res_id, res_ready, busy;
    logic [7:0] res;
    modport master (output req0, a0, b0, req1, a1, b1, res_ready,
                    input  gnt0, gnt1, res_valid, res, res_id, busy);
    modport slave  (input  req0, a0, b0, req1, a1, b1, res_ready,
                    output gnt0, gnt1, res_valid, res, res_id, busy);
endinterface

// File: rtl/mul4s_arbiter.sv
// mul4s_arbiter: round-robin sharing of one 4x4 signed array multiplier between two requesters
module mul4s_arbiter #(
    parameter bit RESET_PTR = 1'b0
) (
    input logic   clk,
    input logic   rst_n,
    mul4s_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
    state_t     state, state_nx;
    logic       ptr, sel, win, cap, acc;
    logic [3:0] opa, opb;
    logic [7:0] ax, prod;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb
        state_nx = state == IDLE ? ((bus.req0 || bus.req1) ? MUL : IDLE) :
                   state == MUL  ? RESP :
                   (bus.res_ready ? IDLE : RESP);

    always_comb begin
        sel = (bus.req0 && bus.req1) ? ptr : bus.req1;
        win = state == IDLE && (bus.req0 || bus.req1);
        cap = state == MUL;
        acc = state == RESP && bus.res_ready;
    end

    // top partial product carries weight -8, so it is subtracted
    always_comb begin
        ax   = {{4{opa[3]}}, opa};
        prod = (opb[0] ? ax : 8'h00) + (opb[1] ? ax << 1 : 8'h00)
             + (opb[2] ? ax << 2 : 8'h00) - (opb[3] ? ax << 3 : 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ptr           <= RESET_PTR;
            opa           <= 4'h0;
            opb           <= 4'h0;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.res       <= 8'h00;
            bus.res_id    <= 1'b0;
            bus.res_valid <= 1'b0;
        end else begin
            bus.gnt0      <= win && !sel;
            bus.gnt1      <= win && sel;
            bus.busy      <= state_nx != IDLE;
            bus.res_valid <= cap || (bus.res_valid && !acc);
            if (win) begin
                opa        <= sel ? bus.a1 : bus.a0;
                opb        <= sel ? bus.b1 : bus.b0;
                bus.res_id <= sel;
                ptr        <= !sel;
            end
            if (cap) bus.res <= prod;
        end
endmodule

// File: tb/tb_mul4s_arbiter.sv
// tb_mul4s_arbiter: directed scoreboard bench for the shared signed-multiplier arbiter
module tb_mul4s_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul4s_if bus();
    mul4s_arbiter #(.RESET_PTR(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] x, y;
        x = {{4{a[3]}}, a};
        y = {{4{b[3]}}, b};
        return x * y;
    endfunction

    task automatic pop_check(input string tag);
        logic [8:0] e;
        check({tag, "_sb"}, 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_res"}, 16'(bus.res), 16'(e[7:0]));
            check({tag, "_id"}, 16'(bus.res_id), 16'(e[8]));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // one request with res_ready high, checked cycle by cycle
    task automatic single(input string tag, input logic id, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        if (id) begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; end
        else    begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; end
        sb.push_back({id, exp});
        @(negedge clk);
        check({tag, "_gnt0"}, 16'(bus.gnt0), 16'(!id));
        check({tag, "_gnt1"}, 16'(bus.gnt1), 16'(id));
        check({tag, "_busy"}, 16'(bus.busy), 16'd1);
        check({tag, "_vld0"}, 16'(bus.res_valid), 16'd0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        check({tag, "_gntclr"}, 16'({bus.gnt1, bus.gnt0}), 16'd0);
        check({tag, "_vld1"}, 16'(bus.res_valid), 16'd1);
        pop_check(tag);
        @(negedge clk);
        check({tag, "_vld2"}, 16'(bus.res_valid), 16'd0);
        check({tag, "_idle"}, 16'(bus.busy), 16'd0);
    endtask

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.res_ready = 1'b1;
        bus.a0 = 4'h0; bus.b0 = 4'h0; bus.a1 = 4'h0; bus.b1 = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 16'({bus.gnt1, bus.gnt0}), 16'd0);
        check("rst_vld", 16'(bus.res_valid), 16'd0);
        check("rst_res", 16'(bus.res), 16'h00);
        check("rst_id", 16'(bus.res_id), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_gnt", 16'({bus.gnt1, bus.gnt0}), 16'd0);
        check("idle_busy", 16'(bus.busy), 16'd0);

        single("r0", 1'b0, 4'h3, 4'hE, 8'hFA);
        single("c88", 1'b1, 4'h8, 4'h8, 8'h40);
        single("c87", 1'b1, 4'h8, 4'h7, 8'hC8);
        single("c08", 1'b1, 4'h0, 4'h8, 8'h00);

        // both requesters held: grants alternate every 3 cycles from RESET_PTR
        do_reset();
        bus.a0 = 4'h7; bus.b0 = 4'h7; bus.a1 = 4'h9; bus.b1 = 4'h5;
        for (int i = 0; i < 2; i++) begin
            sb.push_back({1'b0, smul(4'h7, 4'h7)});
            sb.push_back({1'b1, smul(4'h9, 4'h5)});
        end
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int t = 0; t < 11; t++) begin
            @(negedge clk);
            check("tie_gnt0", 16'(bus.gnt0), 16'(t % 6 == 0));
            check("tie_gnt1", 16'(bus.gnt1), 16'(t % 6 == 3));
            check("tie_vld", 16'(bus.res_valid), 16'(t % 3 == 1));
            if (t % 3 == 1) pop_check("tie");
            if (t == 9) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
        end
        @(negedge clk);
        check("tie_end", 16'({bus.busy, bus.res_valid}), 16'd0);

        // back-pressure with req1 pending
        bus.res_ready = 1'b0;
        bus.req0 = 1'b1; bus.a0 = 4'h5; bus.b0 = 4'h3;
        sb.push_back({1'b0, 8'h0F});
        @(negedge clk);
        check("bp_gnt0", 16'(bus.gnt0), 16'd1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.a1 = 4'hD; bus.b1 = 4'h6;
        repeat (5) begin
            @(negedge clk);
            check("bp_vld", 16'(bus.res_valid), 16'd1);
            check("bp_res", 16'(bus.res), 16'h0F);
            check("bp_id", 16'(bus.res_id), 16'd0);
            check("bp_nognt", 16'(bus.gnt1), 16'd0);
        end
        pop_check("bp");
        sb.push_back({1'b1, smul(4'hD, 4'h6)});
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_acc", 16'({bus.gnt1, bus.busy, bus.res_valid}), 16'd0);
        @(negedge clk);
        check("bp_gnt1", 16'(bus.gnt1), 16'd1);
        bus.req1 = 1'b0;
        @(negedge clk);
        check("bp2_vld", 16'(bus.res_valid), 16'd1);
        pop_check("bp2");
        @(negedge clk);
        check("bp2_done", 16'(bus.res_valid), 16'd0);

        // asynchronous reset while a result is waiting
        bus.res_ready = 1'b0;
        bus.req0 = 1'b1; bus.a0 = 4'h6; bus.b0 = 4'h6;
        @(negedge clk);
        check("ar_gnt0", 16'(bus.gnt0), 16'd1);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("ar_vld", 16'(bus.res_valid), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_vld_drop", 16'(bus.res_valid), 16'd0);
        check("ar_busy", 16'(bus.busy), 16'd0);
        check("ar_res", 16'(bus.res), 16'h00);
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ar_noreplay", 16'({bus.gnt1, bus.gnt0, bus.res_valid}), 16'd0);
        end
        bus.req0 = 1'b1; bus.a0 = 4'h8; bus.b0 = 4'h8;
        bus.req1 = 1'b1; bus.a1 = 4'h1; bus.b1 = 4'h1;
        sb.push_back({1'b0, 8'h40});
        @(negedge clk);
        check("ar_ptr_gnt0", 16'(bus.gnt0), 16'd1);
        check("ar_ptr_gnt1", 16'(bus.gnt1), 16'd0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(negedge clk);
        check("ar2_vld", 16'(bus.res_valid), 16'd1);
        pop_check("ar2");
        @(negedge clk);
        check("ar2_done", 16'(bus.res_valid), 16'd0);
        check("sb_empty", 16'(sb.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
